// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_arbiter
//  Purpose  : Shares one downstream req/addr_ok/data_ok memory channel between
//             an instruction requester and a data requester. Grants are held
//             until accepted, and accepted transactions are tracked in order
//             so each response is routed back to its owner.
//  Options  : MEM_ARB_ROUND_ROBIN_EN - replaces fixed data priority and the
//             instruction starvation counter with last-winner round robin.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8,
    parameter int DATA_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    // instruction requester
    input  logic              inst_req,
    input  logic [31:0]       inst_addr,
    input  logic [2:0]        inst_size,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    // data requester
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [2:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [3:0]        data_wstrb,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    // downstream channel
    output logic              mem_req,
    output logic              mem_wr,
    output logic [2:0]        mem_size,
    output logic [31:0]       mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              resp_err
);

    localparam int         c_PTR_W    = $clog2(MAX_OUTSTANDING);
    localparam int         c_CNT_W    = c_PTR_W + 1;
    localparam logic       c_SRC_INST = 1'b0;
    localparam logic       c_SRC_DATA = 1'b1;

    logic [MAX_OUTSTANDING-1:0] r_fifo_src;
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_CNT_W-1:0]         r_count;
    logic                       r_lock;
    logic                       r_lock_src;
    logic                       r_resp_err;

    logic                       w_full;
    logic                       w_not_empty;
    logic                       w_arb_src;
    logic                       w_grant_src;
    logic                       w_accept;
    logic                       w_pop;
    logic                       w_head_src;

    assign w_full      = (r_count == c_CNT_W'(MAX_OUTSTANDING));
    assign w_not_empty = (r_count != '0);
    assign w_head_src  = r_fifo_src[r_rd_ptr];

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_src;

    // Round robin: on contention favour the side that lost the last accept
    always_comb begin
        w_arb_src = c_SRC_INST;
        if (inst_req && data_req) begin
            w_arb_src = ~r_last_src;
        end else if (data_req) begin
            w_arb_src = c_SRC_DATA;
        end
    end

    // Remember which side won the most recent accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_src <= c_SRC_INST;
        end else if (w_accept) begin
            r_last_src <= w_grant_src;
        end
    end
`else
    localparam logic [7:0] c_STARVE_MAX = 8'(STARVE_LIMIT);
    logic [7:0] r_starve;

    // Fixed data priority, overridden once the instruction side has starved
    always_comb begin
        w_arb_src = c_SRC_INST;
        if (inst_req && (r_starve == c_STARVE_MAX)) begin
            w_arb_src = c_SRC_INST;
        end else if (data_req) begin
            w_arb_src = c_SRC_DATA;
        end
    end

    // Count consecutive cycles an instruction request waits without acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (inst_req && !inst_addr_ok) begin
            if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 8'd1;
            end
        end else begin
            r_starve <= '0;
        end
    end
`endif

    // A locked grant ignores the arbiter until the request is accepted
    assign w_grant_src = r_lock ? r_lock_src : w_arb_src;

    // No bypass: a full tracker blocks requests even if a pop is in flight
    assign mem_req  = ~w_full & (r_lock | inst_req | data_req);
    assign w_accept = mem_req & mem_addr_ok;
    assign w_pop    = mem_data_ok & w_not_empty;

    assign inst_addr_ok = w_accept & (w_grant_src == c_SRC_INST);
    assign data_addr_ok = w_accept & (w_grant_src == c_SRC_DATA);

    // Request payload mux; instruction fetches are always reads
    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wstrb = 4'b0000;
        mem_wdata = '0;
        if (w_grant_src == c_SRC_DATA) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wstrb = data_wstrb;
            mem_wdata = data_wdata;
        end
    end

    // Hold the grant while the downstream stalls, release on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock     <= 1'b0;
            r_lock_src <= c_SRC_INST;
        end else if (w_accept) begin
            r_lock     <= 1'b0;
        end else if (mem_req) begin
            r_lock     <= 1'b1;
            r_lock_src <= w_grant_src;
        end
    end

    // In-order tracker of source IDs for accepted transactions
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo_src <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_accept) begin
                r_fifo_src[r_wr_ptr] <= w_grant_src;
                r_wr_ptr             <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Sticky flag for responses that have no matching transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_err <= 1'b0;
        end else if (mem_data_ok && !w_not_empty) begin
            r_resp_err <= 1'b1;
        end
    end

    assign resp_err     = r_resp_err;
    assign inst_data_ok = w_pop & (w_head_src == c_SRC_INST);
    assign data_data_ok = w_pop & (w_head_src == c_SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_req_arbiter
//  Purpose  : Self-checking bench for mem_req_arbiter: directed vector table,
//             starvation sequence, and randomized traffic against a
//             queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;

    localparam int MAXO = 4;
    localparam int SL   = 8;
    localparam int DW   = 32;
    localparam logic [31:0] IA = 32'h1FC0_0000;
    localparam logic [31:0] DA = 32'h8000_1000;

    logic          clk, reset;
    logic          inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0]   inst_addr;
    logic [2:0]    inst_size;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_wr, data_addr_ok, data_data_ok;
    logic [2:0]    data_size;
    logic [31:0]   data_addr;
    logic [3:0]    data_wstrb;
    logic [DW-1:0] data_wdata, data_rdata;
    logic          mem_req, mem_wr, mem_addr_ok, mem_data_ok, resp_err;
    logic [2:0]    mem_size;
    logic [31:0]   mem_addr;
    logic [3:0]    mem_wstrb;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_req_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ireq, dreq, aok, dok;
        logic [31:0] rdata;
        logic        mreq, iaok, daok, idok, ddok, err;
        logic [31:0] maddr;
    } vec_t;

    function automatic vec_t mk(input logic ireq, dreq, aok, dok, input logic [31:0] rd,
                                input logic mreq, iaok, daok, idok, ddok, err,
                                input logic [31:0] ma);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok; v.rdata = rd;
        v.mreq = mreq; v.iaok = iaok; v.daok = daok; v.idok = idok; v.ddok = ddok;
        v.err = err; v.maddr = ma;
        return v;
    endfunction

    task automatic idle_inputs();
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
        inst_addr = IA; inst_size = 3'd2;
        data_addr = DA; data_wr = 0; data_size = 3'd2; data_wstrb = 4'hF; data_wdata = '0;
    endtask

    // reference model state
    bit q[$];
    int m_starve;
    bit m_lock, m_lock_data, m_err, m_last_data;

    task automatic model_reset();
        q.delete();
        m_starve = 0; m_lock = 0; m_lock_data = 0; m_err = 0; m_last_data = 0;
    endtask

    vec_t tbl[34];

    initial begin
        bit ipend, dpend, do_rst, g_data, e_mreq, e_acc, e_iaok, e_daok, e_idok, e_ddok;

        // directed scenarios: single read, contention, lock, full, spurious
        tbl[0]  = mk(1,0,0,0,32'h0,        1,0,0,0,0,0,IA);
        tbl[1]  = mk(1,0,1,0,32'h0,        1,1,0,0,0,0,IA);
        tbl[2]  = mk(0,0,0,0,32'h0,        0,0,0,0,0,0,0);
        tbl[3]  = mk(0,0,0,0,32'h0,        0,0,0,0,0,0,0);
        tbl[4]  = mk(0,0,0,1,32'hDEADBEEF, 0,0,0,1,0,0,0);
        tbl[5]  = mk(1,1,1,0,32'h0,        1,0,1,0,0,0,DA);
        tbl[6]  = mk(1,0,1,0,32'h0,        1,1,0,0,0,0,IA);
        tbl[7]  = mk(0,0,0,1,32'h11111111, 0,0,0,0,1,0,0);
        tbl[8]  = mk(0,0,0,1,32'h22222222, 0,0,0,1,0,0,0);
        for (int i = 9; i <= 13; i++) tbl[i] = mk(0,1,0,0,32'h0, 1,0,0,0,0,0,DA);
        tbl[14] = mk(1,0,0,0,32'h0,        1,0,0,0,0,0,DA);
        tbl[15] = mk(1,0,1,0,32'h0,        1,0,1,0,0,0,DA);
        tbl[16] = mk(1,0,1,0,32'h0,        1,1,0,0,0,0,IA);
        tbl[17] = mk(0,0,0,1,32'h33333333, 0,0,0,0,1,0,0);
        tbl[18] = mk(0,0,0,1,32'h44444444, 0,0,0,1,0,0,0);
        for (int i = 19; i <= 22; i++) tbl[i] = mk(0,1,1,0,32'h0, 1,0,1,0,0,0,DA);
        tbl[23] = mk(0,1,1,0,32'h0,        0,0,0,0,0,0,0);
        tbl[24] = mk(0,1,1,1,32'h55555555, 0,0,0,0,1,0,0);
        tbl[25] = mk(0,1,0,0,32'h0,        1,0,0,0,0,0,DA);
        tbl[26] = mk(0,1,1,0,32'h0,        1,0,1,0,0,0,DA);
        for (int i = 27; i <= 30; i++) tbl[i] = mk(0,0,0,1,32'h66666666, 0,0,0,0,1,0,0);
        tbl[31] = mk(0,0,0,1,32'h77777777, 0,0,0,0,0,0,0);
        tbl[32] = mk(0,0,0,0,32'h0,        0,0,0,0,0,1,0);
        tbl[33] = mk(0,0,0,0,32'h0,        0,0,0,0,0,1,0);

        // reset state
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        #4;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        chk("rst_resp_err", resp_err, 0);

        // vector table
        for (int i = 0; i < 34; i++) begin
            @(posedge clk); #1;
            inst_req = tbl[i].ireq; data_req = tbl[i].dreq;
            mem_addr_ok = tbl[i].aok; mem_data_ok = tbl[i].dok; mem_rdata = tbl[i].rdata;
            #4;
            chk($sformatf("v%0d_mem_req", i), mem_req, tbl[i].mreq);
            chk($sformatf("v%0d_inst_addr_ok", i), inst_addr_ok, tbl[i].iaok);
            chk($sformatf("v%0d_data_addr_ok", i), data_addr_ok, tbl[i].daok);
            chk($sformatf("v%0d_inst_data_ok", i), inst_data_ok, tbl[i].idok);
            chk($sformatf("v%0d_data_data_ok", i), data_data_ok, tbl[i].ddok);
            chk($sformatf("v%0d_resp_err", i), resp_err, tbl[i].err);
            if (tbl[i].mreq) chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].maddr);
            if (tbl[i].idok) chk($sformatf("v%0d_inst_rdata", i), inst_rdata, tbl[i].rdata);
            if (tbl[i].ddok) chk($sformatf("v%0d_data_rdata", i), data_rdata, tbl[i].rdata);
        end

        // reset clears the sticky error
        @(posedge clk); #1;
        idle_inputs(); reset = 1;
        @(posedge clk); #1 reset = 0;
        #4;
        chk("err_cleared", resp_err, 0);
        chk("err_cleared_mem_req", mem_req, 0);

`ifndef MEM_ARB_ROUND_ROBIN_EN
        // starvation: both sides request every cycle, downstream always ready
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = (k > 1);
            mem_rdata = 32'(k);
            #4;
            chk($sformatf("starve%0d_inst_addr_ok", k), inst_addr_ok, (k == 9));
            chk($sformatf("starve%0d_data_addr_ok", k), data_addr_ok, (k != 9));
            chk($sformatf("starve%0d_inst_data_ok", k), inst_data_ok, (k == 10));
            chk($sformatf("starve%0d_data_data_ok", k), data_data_ok, (k >= 2 && k <= 9));
        end
        @(posedge clk); #1;
        idle_inputs(); mem_data_ok = 1;
        #4;
        chk("starve_drain_data_ok", data_data_ok, 1);
        chk("starve_drain_err", resp_err, 0);
`endif

        // randomized traffic against the reference model
        @(posedge clk); #1;
        idle_inputs(); reset = 1;
        @(posedge clk); #1 reset = 0;
        model_reset();
        ipend = 0; dpend = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c != 0) begin @(posedge clk); #1; end
            do_rst = ($urandom % 300 == 0);
            if (!ipend && ($urandom % 3 != 0)) begin
                ipend = 1; inst_addr = $urandom; inst_size = 3'($urandom);
            end
            if (!dpend && ($urandom % 4 != 0)) begin
                dpend = 1; data_addr = $urandom; data_size = 3'($urandom);
                data_wr = 1'($urandom); data_wstrb = 4'($urandom); data_wdata = $urandom;
            end
            inst_req = ipend; data_req = dpend; reset = do_rst;
            mem_addr_ok = do_rst ? 1'b0 : ($urandom % 10 < 7);
            mem_data_ok = do_rst ? 1'b0 :
                          (q.size() > 0) ? ($urandom % 10 < 4) : ($urandom % 150 == 0);
            mem_rdata = $urandom;
            #4;
            if (do_rst) begin
                model_reset();
                continue;
            end
            if (m_lock) g_data = m_lock_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            else if (inst_req && data_req) g_data = !m_last_data;
`else
            else if (inst_req && m_starve >= SL) g_data = 0;
`endif
            else g_data = data_req;
            e_mreq = (q.size() < MAXO) && (m_lock || inst_req || data_req);
            e_acc  = e_mreq && mem_addr_ok;
            e_iaok = e_acc && !g_data;
            e_daok = e_acc && g_data;
            e_idok = mem_data_ok && q.size() > 0 && q[0] == 0;
            e_ddok = mem_data_ok && q.size() > 0 && q[0] == 1;
            chk("rnd_mem_req", mem_req, e_mreq);
            chk("rnd_inst_addr_ok", inst_addr_ok, e_iaok);
            chk("rnd_data_addr_ok", data_addr_ok, e_daok);
            chk("rnd_inst_data_ok", inst_data_ok, e_idok);
            chk("rnd_data_data_ok", data_data_ok, e_ddok);
            chk("rnd_resp_err", resp_err, m_err);
            if (e_mreq) begin
                chk("rnd_mem_addr", mem_addr, g_data ? data_addr : inst_addr);
                chk("rnd_mem_size", mem_size, g_data ? data_size : inst_size);
                chk("rnd_mem_wr", mem_wr, g_data ? data_wr : 1'b0);
                chk("rnd_mem_wstrb", mem_wstrb, g_data ? data_wstrb : 4'h0);
                if (g_data) chk("rnd_mem_wdata", mem_wdata, data_wdata);
            end
            if (e_idok) chk("rnd_inst_rdata", inst_rdata, mem_rdata);
            if (e_ddok) chk("rnd_data_rdata", data_rdata, mem_rdata);
            // advance model to the next cycle
            if (mem_data_ok) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_err = 1;
            end
            if (e_acc) begin
                q.push_back(g_data); m_lock = 0; m_last_data = g_data;
            end else if (e_mreq) begin
                m_lock = 1; m_lock_data = g_data;
            end
            if (inst_req && !e_iaok) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
            else m_starve = 0;
            if (e_iaok) ipend = 0;
            if (e_daok) dpend = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
